// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 stream cipher: the controller state encoding
// and the cycle-budget constants that fix the session start-up latency.
// -----------------------------------------------------------------------------
package rc4_pkg;

  localparam int SBOX_SIZE   = 256;
  localparam int INIT_CYCLES = 128;  // two S-box entries written per cycle
  localparam int KSA_CYCLES  = 768;  // read S[i], read S[j], write-swap
  localparam int PRGA_CYCLES = 4;    // read i, read j, swap, read keystream

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_RD_I,
    ST_KSA_RD_J,
    ST_KSA_WR,
    ST_PRGA_RD_I,
    ST_PRGA_RD_J,
    ST_PRGA_SWAP,
    ST_PRGA_RD_K,
    ST_KS_RDY
  } rc4_state_e;

endpackage : rc4_pkg

// File: rtl/dual_port_ram.sv
// -----------------------------------------------------------------------------
// dual_port_ram
// Two read/write ports, one-cycle registered read (old data on a same-cycle
// write to the same address).
//   clk_a/clk_b  : port clocks; writes from both ports are serviced on clk_a,
//                  so this block must be used with clk_b tied to clk_a
//   en_x, we_x   : port enable / write enable
//   addr_x       : port address
//   din_x        : write data
//   dout_x       : registered read data
// When both ports write the same address in one cycle, port B's data lands.
// -----------------------------------------------------------------------------
module dual_port_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_a,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  clk_b,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // NOTE: the storage array has no reset; a RAM macro cannot clear itself in
  // one cycle, and every user is expected to initialise contents before use.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_a_q;
  logic [DATA_WIDTH-1:0] dout_b_q;

  always_ff @(posedge clk_a) begin
    if (en_a && we_a) mem_q[addr_a] <= din_a;
    if (en_b && we_b) mem_q[addr_b] <= din_b;
    if (en_a)         dout_a_q      <= mem_q[addr_a];
  end

  always_ff @(posedge clk_b) begin
    if (en_b) dout_b_q <= mem_q[addr_b];
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;

endmodule : dual_port_ram

// File: rtl/rc4_stream_cipher.sv
// -----------------------------------------------------------------------------
// rc4_stream_cipher
// RC4 (optionally RC4-drop[N]) keystream generator XORed onto a byte stream.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   key_load     : one-cycle pulse, captures key and (re)starts a session
//   key          : KEY_BYTES bytes, byte 0 in key[7:0]
//   in_valid/in_ready/in_data    : input byte handshake
//   out_valid/out_ready/out_data : output byte handshake (in_data ^ keystream)
//   busy         : high while the S-box is initialised, scheduled or dropping
//   byte_count   : bytes accepted since the last key_load (wraps)
// The S-box lives in a dual-port RAM with registered reads, so every S-box
// access is issued in one state and consumed in the next.
// -----------------------------------------------------------------------------
module rc4_stream_cipher
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_load,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   busy,
  output logic [31:0]            byte_count
);

  if (KEY_BYTES < 1 || KEY_BYTES > 32) begin : g_bad_key_bytes
    $fatal(1, "rc4_stream_cipher: KEY_BYTES=%0d outside 1..32", KEY_BYTES);
  end
  if (DROP_N < 0 || DROP_N > 4095) begin : g_bad_drop_n
    $fatal(1, "rc4_stream_cipher: DROP_N=%0d outside 0..4095", DROP_N);
  end
  if (2 * INIT_CYCLES != SBOX_SIZE || KSA_CYCLES != 3 * SBOX_SIZE ||
      PRGA_CYCLES != 4) begin : g_bad_schedule
    $fatal(1, "rc4_stream_cipher: cycle budget does not match state sequence");
  end

  localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [11:0]       DROP_INIT = 12'(DROP_N);
  localparam logic [7:0]        INIT_LAST = 8'(SBOX_SIZE - 2);
  localparam logic [7:0]        KSA_LAST  = 8'(SBOX_SIZE - 1);

  rc4_state_e             state_q;
  logic [KEY_BYTES*8-1:0] key_q;
  logic [7:0]             i_q, j_q, si_q, sj_q;
  logic [KIDX_W-1:0]      kidx_q;
  logic [11:0]            drop_q;
  logic                   out_valid_q, busy_q;
  logic [7:0]             out_data_q;
  logic [31:0]            byte_count_q;

  logic       ram_we_a, ram_we_b;
  logic [7:0] ram_addr_a, ram_addr_b, ram_din_a, ram_din_b;
  logic [7:0] ram_dout_a, ram_dout_b;
  logic [7:0] key_byte, ksa_j_d, prga_j_d;
  logic       accept;

  // Key byte for the current KSA step, selected by the wrapping key index.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KIDX_W'(k)) key_byte = key_q[k*8 +: 8];
    end
  end

  // ram_dout_a holds S[i] in both RD_J states (read issued one state earlier).
  assign ksa_j_d  = j_q + ram_dout_a + key_byte;
  assign prga_j_d = j_q + ram_dout_a;

  assign in_ready = (state_q == ST_KS_RDY) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // S-box port steering. Port A follows i, port B follows j; the swap writes
  // S[i] <= S[j] on A and S[j] <= S[i] on B, so i == j rewrites one entry with
  // its own value.
  always_comb begin
    // NOTE: every output of this block gets a default first so that states
    // which leave a signal untouched cannot infer a latch.
    ram_we_a   = 1'b0;
    ram_we_b   = 1'b0;
    ram_addr_a = i_q;
    ram_addr_b = j_q;
    ram_din_a  = ram_dout_b;
    ram_din_b  = si_q;
    unique case (state_q)
      ST_INIT: begin
        ram_we_a   = 1'b1;
        ram_we_b   = 1'b1;
        ram_din_a  = i_q;
        ram_addr_b = i_q + 8'd1;
        ram_din_b  = i_q + 8'd1;
      end
      ST_KSA_RD_J:               ram_addr_b = ksa_j_d;
      ST_KSA_WR, ST_PRGA_SWAP: begin
        ram_we_a = 1'b1;
        ram_we_b = 1'b1;
      end
      ST_PRGA_RD_I:              ram_addr_a = i_q + 8'd1;
      ST_PRGA_RD_J:              ram_addr_b = prga_j_d;
      // Keep re-reading S[S[i]+S[j]] so the keystream byte stays on dout_a
      // for as long as the block waits in KS_RDY.
      ST_PRGA_RD_K, ST_KS_RDY:   ram_addr_a = si_q + sj_q;
      default: ;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      i_q          <= '0;
      j_q          <= '0;
      si_q         <= '0;
      sj_q         <= '0;
      kidx_q       <= '0;
      drop_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      byte_count_q <= '0;
    end else if (key_load) begin
      state_q      <= ST_INIT;
      key_q        <= key;
      i_q          <= '0;
      j_q          <= '0;
      kidx_q       <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b1;
      byte_count_q <= '0;
    end else begin
      // A completed output transfer empties the output register; an accept
      // later in this block refills it in the same edge.
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      unique case (state_q)
        ST_INIT: begin
          i_q <= i_q + 8'd2;
          if (i_q == INIT_LAST) begin
            i_q     <= '0;
            state_q <= ST_KSA_RD_I;
          end
        end
        ST_KSA_RD_I: state_q <= ST_KSA_RD_J;
        ST_KSA_RD_J: begin
          j_q     <= ksa_j_d;
          si_q    <= ram_dout_a;
          state_q <= ST_KSA_WR;
        end
        ST_KSA_WR: begin
          kidx_q <= (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
          if (i_q == KSA_LAST) begin
            i_q     <= '0;
            j_q     <= '0;
            drop_q  <= DROP_INIT;
            busy_q  <= (DROP_N != 0);
            state_q <= ST_PRGA_RD_I;
          end else begin
            i_q     <= i_q + 8'd1;
            state_q <= ST_KSA_RD_I;
          end
        end
        ST_PRGA_RD_I: begin
          i_q     <= i_q + 8'd1;
          state_q <= ST_PRGA_RD_J;
        end
        ST_PRGA_RD_J: begin
          j_q     <= prga_j_d;
          si_q    <= ram_dout_a;
          state_q <= ST_PRGA_SWAP;
        end
        ST_PRGA_SWAP: begin
          sj_q    <= ram_dout_b;
          state_q <= ST_PRGA_RD_K;
        end
        ST_PRGA_RD_K: begin
          if (drop_q != '0) begin
            // Busy ends with the last discarded byte, not the kept one.
            drop_q  <= drop_q - 12'd1;
            busy_q  <= (drop_q > 12'd1);
            state_q <= ST_PRGA_RD_I;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_KS_RDY;
          end
        end
        ST_KS_RDY: begin
          if (accept) begin
            out_data_q   <= in_data ^ ram_dout_a;
            out_valid_q  <= 1'b1;
            byte_count_q <= byte_count_q + 32'd1;
            state_q      <= ST_PRGA_RD_I;
          end
        end
        default: ;  // IDLE waits for key_load
      endcase
    end
  end

  dual_port_ram #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8)
  ) u_sbox (
    .clk_a  (clk),
    .en_a   (1'b1),
    .we_a   (ram_we_a),
    .addr_a (ram_addr_a),
    .din_a  (ram_din_a),
    .dout_a (ram_dout_a),
    .clk_b  (clk),
    .en_b   (1'b1),
    .we_b   (ram_we_b),
    .addr_b (ram_addr_b),
    .din_b  (ram_din_b),
    .dout_b (ram_dout_b)
  );

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign byte_count = byte_count_q;

endmodule : rc4_stream_cipher

// File: tb/tb_rc4_stream_cipher.sv
// -----------------------------------------------------------------------------
// tb_rc4_stream_cipher
// Main instance uses a 12-byte key so that 3-, 4- and 6-byte keys can be
// presented as repeated patterns ("KeyKeyKeyKey" behaves as "Key").
// A second instance covers RC4-drop[1].
// -----------------------------------------------------------------------------
module tb_rc4_stream_cipher;

  localparam int KB = 12;
  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key_load = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [KB*8-1:0] key = '0;
  logic [7:0]    in_data = '0, out_data;
  logic          in_ready, out_valid, busy;
  logic [31:0]   byte_count;

  logic          d_key_load = 1'b0, d_in_valid = 1'b0, d_out_ready = 1'b1;
  logic [23:0]   d_key = '0;
  logic [7:0]    d_in_data = '0, d_out_data;
  logic          d_in_ready, d_out_valid, d_busy;
  logic [31:0]   d_byte_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rc4_stream_cipher #(.KEY_BYTES(KB), .DROP_N(0)) u_dut (
    .clk(clk), .reset(reset), .key_load(key_load), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .byte_count(byte_count)
  );

  rc4_stream_cipher #(.KEY_BYTES(3), .DROP_N(1)) u_drop (
    .clk(clk), .reset(reset), .key_load(d_key_load), .key(d_key),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .busy(d_busy), .byte_count(d_byte_count)
  );

  // ---------------- reference model and helpers ----------------
  function automatic bq_t str2q(string s);
    bq_t q;
    for (int n = 0; n < s.len(); n++) q.push_back(s[n]);
    return q;
  endfunction

  function automatic bq_t rep(bq_t b, int len);
    bq_t q;
    for (int n = 0; n < len; n++) q.push_back(b[n % b.size()]);
    return q;
  endfunction

  function automatic logic [KB*8-1:0] pack_key(bq_t kb);
    logic [KB*8-1:0] v = '0;
    for (int k = 0; k < KB; k++) v[k*8 +: 8] = kb[k];
    return v;
  endfunction

  // Textbook RC4: key schedule, then PRGA, discarding the first 'drop' bytes.
  function automatic bq_t rc4_model(bq_t kb, int drop, int n);
    int s[256];
    int i, j, t;
    bq_t ks;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + int'(kb[x % kb.size()])) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int c = 0; c < drop + n; c++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (c >= drop) ks.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
    return ks;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_key(input bq_t kb);
    key = pack_key(kb);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Cycles from the key_load edge until in_ready is seen.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!in_ready && cyc < 3000) begin
      tick();
      cyc++;
    end
  endtask

  // Streams din through the main instance and collects what comes out.
  // While a stall window is active, counts out_data changes and in_ready highs.
  task automatic stream(input bq_t din, input bit rand_ready, input int stall_after,
                        input int stall_len, output bq_t dout, output int stall_viol,
                        output int stall_samples, output bit timed_out);
    int sent = 0, cyc = 0, stall_left = 0;
    bit stalled_once = 0, have_held = 0;
    logic [7:0] held = '0;
    dout = {};
    stall_viol = 0;
    stall_samples = 0;
    while (dout.size() < din.size() && cyc < 2000 + 10 * din.size()) begin
      if (!stalled_once && stall_after >= 0 && dout.size() == stall_after) begin
        stall_left = stall_len;
        stalled_once = 1;
      end
      in_valid  = (sent < din.size());
      in_data   = (sent < din.size()) ? din[sent] : 8'h00;
      out_ready = (stall_left > 0) ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      @(negedge clk);
      if (stall_left > 0 && out_valid) begin
        stall_samples++;
        if (have_held && out_data !== held) stall_viol++;
        if (in_ready !== 1'b0) stall_viol++;
        held = out_data;
        have_held = 1;
      end
      if (out_valid && out_ready) dout.push_back(out_data);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
      if (stall_left > 0) stall_left--;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    timed_out = (dout.size() < din.size());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (byte_count !== 32'd0) begin failures++; $display("FAIL reset_byte_count got=%0d exp=0", byte_count); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%02h exp=00", out_data); end
    checks++; if (d_in_ready !== 1'b0 || d_busy !== 1'b0) begin failures++; $display("FAIL reset_drop_inst got=%b%b exp=00", d_in_ready, d_busy); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_known_key(input string name);
    bq_t dout, expv;
    int cyc, sv, ss;
    bit to;
    expv = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    load_key(rep(str2q("Key"), KB));
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy_init got=%b exp=1", name, busy); end
    tick();
    wait_ready(cyc);
    cyc++;  // the tick above is part of the latency
    checks++; if (cyc != 900) begin failures++; $display("FAIL %s_first_ready got=%0d exp=900", name, cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_ready got=%b exp=0", name, busy); end
    stream(str2q("Plaintext"), 1'b0, -1, 0, dout, sv, ss, to);
    checks++; if (to) begin failures++; $display("FAIL %s_timeout got=%0d exp=%0d bytes", name, dout.size(), expv.size()); end
    for (int n = 0; n < expv.size(); n++) begin
      logic [7:0] g = (n < dout.size()) ? dout[n] : 8'hxx;
      checks++; if (g !== expv[n]) begin failures++; $display("FAIL %s_byte%0d got=%02h exp=%02h", name, n, g, expv[n]); end
    end
    checks++; if (byte_count !== 32'd9) begin failures++; $display("FAIL %s_byte_count got=%0d exp=9", name, byte_count); end
  endtask

  task automatic test_secret();
    bq_t dout, expv;
    int cyc, sv, ss;
    bit to;
    expv = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
    load_key(rep(str2q("Secret"), KB));
    wait_ready(cyc);
    checks++; if (cyc != 900) begin failures++; $display("FAIL secret_first_ready got=%0d exp=900", cyc); end
    stream(str2q("Attack at dawn"), 1'b0, -1, 0, dout, sv, ss, to);
    checks++; if (to) begin failures++; $display("FAIL secret_timeout got=%0d exp=14 bytes", dout.size()); end
    for (int n = 0; n < expv.size(); n++) begin
      logic [7:0] g = (n < dout.size()) ? dout[n] : 8'hxx;
      checks++; if (g !== expv[n]) begin failures++; $display("FAIL secret_byte%0d got=%02h exp=%02h", n, g, expv[n]); end
    end
  endtask

  task automatic test_wiki_stall();
    bq_t dout, expv;
    int cyc, sv, ss;
    bit to;
    expv = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    load_key(rep(str2q("Wiki"), KB));
    wait_ready(cyc);
    stream(str2q("pedia"), 1'b0, 2, 10, dout, sv, ss, to);
    checks++; if (to) begin failures++; $display("FAIL wiki_timeout got=%0d exp=5 bytes", dout.size()); end
    for (int n = 0; n < expv.size(); n++) begin
      logic [7:0] g = (n < dout.size()) ? dout[n] : 8'hxx;
      checks++; if (g !== expv[n]) begin failures++; $display("FAIL wiki_byte%0d got=%02h exp=%02h", n, g, expv[n]); end
    end
    checks++; if (ss == 0) begin failures++; $display("FAIL wiki_stall_seen got=%0d exp>0 stalled cycles", ss); end
    checks++; if (sv != 0) begin failures++; $display("FAIL wiki_stall_hold got=%0d exp=0 violations", sv); end
    checks++; if (byte_count !== 32'd5) begin failures++; $display("FAIL wiki_byte_count got=%0d exp=5", byte_count); end
  endtask

  task automatic test_rekey();
    bq_t dout, expv;
    int cyc, sv, ss, guard;
    bit to;
    expv = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    load_key(rep(str2q("Key"), KB));
    wait_ready(cyc);
    stream(str2q("P"), 1'b0, -1, 0, dout, sv, ss, to);
    checks++; if (dout.size() != 1 || dout[0] !== 8'hBB) begin failures++; $display("FAIL rekey_first_byte got=%0d bytes exp=1 byte BB", dout.size()); end
    // Second byte accepted but left stalled in the output register.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = "l";
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready || guard > 50) break;
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || byte_count !== 32'd2) begin failures++; $display("FAIL rekey_pre got=%b/%0d exp=1/2", out_valid, byte_count); end
    tick();
    key = pack_key(rep(str2q("Wiki"), KB));
    key_load = 1'b1;
    in_valid = 1'b1;
    tick();
    key_load = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rekey_out_valid got=%b exp=0", out_valid); end
    checks++; if (byte_count !== 32'd0) begin failures++; $display("FAIL rekey_byte_count got=%0d exp=0", byte_count); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rekey_busy got=%b exp=1", busy); end
    out_ready = 1'b1;
    tick();
    wait_ready(cyc);
    cyc++;
    checks++; if (cyc != 900) begin failures++; $display("FAIL rekey_first_ready got=%0d exp=900", cyc); end
    stream(str2q("pedia"), 1'b0, -1, 0, dout, sv, ss, to);
    for (int n = 0; n < expv.size(); n++) begin
      logic [7:0] g = (n < dout.size()) ? dout[n] : 8'hxx;
      checks++; if (g !== expv[n]) begin failures++; $display("FAIL rekey_byte%0d got=%02h exp=%02h", n, g, expv[n]); end
    end
  endtask

  task automatic test_reset_ksa();
    bit saw_ready = 0;
    load_key(rep(str2q("Key"), KB));
    repeat (300) tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rksa_busy_ksa got=%b exp=1", busy); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL rksa_handshake got=%b%b exp=00", out_valid, in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rksa_busy got=%b exp=0", busy); end
    checks++; if (byte_count !== 32'd0) begin failures++; $display("FAIL rksa_byte_count got=%0d exp=0", byte_count); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rksa_out_data got=%02h exp=00", out_data); end
    for (int n = 0; n < 950; n++) begin
      tick();
      if (in_ready) saw_ready = 1;
    end
    checks++; if (saw_ready) begin failures++; $display("FAIL rksa_idle_ready got=1 exp=0"); end
    test_known_key("rksa");
  endtask

  task automatic test_drop();
    bq_t model;
    logic [7:0] got [2];
    logic [7:0] expv [2];
    int cyc, guard;
    logic busy_at_898 = 1'b0;
    expv[0] = 8'h9F;
    expv[1] = 8'h77;
    model = rc4_model(str2q("Key"), 1, 2);
    d_key = "yeK";
    d_key_load = 1'b1;
    tick();
    d_key_load = 1'b0;
    cyc = 0;
    while (!d_in_ready && cyc < 3000) begin
      tick();
      cyc++;
      if (cyc == 898) busy_at_898 = d_busy;
    end
    checks++; if (cyc != 904) begin failures++; $display("FAIL drop_first_ready got=%0d exp=904", cyc); end
    checks++; if (busy_at_898 !== 1'b1) begin failures++; $display("FAIL drop_busy_dropping got=%b exp=1", busy_at_898); end
    checks++; if (d_busy !== 1'b0) begin failures++; $display("FAIL drop_busy_ready got=%b exp=0", d_busy); end
    for (int b = 0; b < 2; b++) begin
      d_in_valid = 1'b1;
      d_in_data = 8'h00;
      guard = 0;
      forever begin
        @(negedge clk);
        if (d_in_ready || guard > 50) break;
        tick();
        guard++;
      end
      tick();
      d_in_valid = 1'b0;
      got[b] = 8'hxx;
      guard = 0;
      forever begin
        @(negedge clk);
        if (d_out_valid) begin got[b] = d_out_data; break; end
        if (guard > 50) break;
        tick();
        guard++;
      end
      tick();
      checks++; if (got[b] !== expv[b]) begin failures++; $display("FAIL drop_byte%0d got=%02h exp=%02h", b, got[b], expv[b]); end
      checks++; if (got[b] !== model[b]) begin failures++; $display("FAIL drop_model%0d got=%02h exp=%02h", b, got[b], model[b]); end
    end
    checks++; if (d_byte_count !== 32'd2) begin failures++; $display("FAIL drop_byte_count got=%0d exp=2", d_byte_count); end
  endtask

  task automatic test_random();
    bq_t kb, pt, ks, dout;
    int cyc, sv, ss, n;
    bit to;
    for (int it = 0; it < 3; it++) begin
      kb = {};
      pt = {};
      for (int k = 0; k < KB; k++) kb.push_back(8'($urandom_range(0, 255)));
      n = $urandom_range(5, 16);
      for (int k = 0; k < n; k++) pt.push_back(8'($urandom_range(0, 255)));
      ks = rc4_model(kb, 0, n);
      load_key(kb);
      wait_ready(cyc);
      stream(pt, 1'b1, -1, 0, dout, sv, ss, to);
      checks++; if (to) begin failures++; $display("FAIL rand%0d_timeout got=%0d exp=%0d bytes", it, dout.size(), n); end
      for (int k = 0; k < n; k++) begin
        logic [7:0] g = (k < dout.size()) ? dout[k] : 8'hxx;
        logic [7:0] e = pt[k] ^ ks[k];
        checks++; if (g !== e) begin failures++; $display("FAIL rand%0d_byte%0d got=%02h exp=%02h", it, k, g, e); end
      end
      checks++; if (byte_count !== 32'(n)) begin failures++; $display("FAIL rand%0d_byte_count got=%0d exp=%0d", it, byte_count, n); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_drop();
    test_known_key("key");
    test_secret();
    test_wiki_stall();
    test_rekey();
    test_reset_ksa();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rc4_stream_cipher
